// File: rtl/alu.sv
// rtl/alu.sv - 32-bit registered ALU with MVHI partial write; optional flags via ALU_FLAGS_EN
module alu #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   opsel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ALU_FLAGS_EN
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf,
`endif
  output logic [WIDTH-1:0] out
);

  localparam int HALF = WIDTH / 2;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_NAND = OPW'(5);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(6);
  localparam logic [OPW-1:0] OP_XNOR = OPW'(7);
  localparam logic [OPW-1:0] OP_MVHI = OPW'(8);

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] next_out;

`ifdef ALU_FLAGS_EN
  logic add_carry;
  logic sub_borrow;
  logic reserved;
  logic next_cf;
  logic next_vf;

  // Widened add/sub so the carry and borrow fall out of the top bit
  always_comb begin
    {add_carry, add_res}  = {1'b0, A} + {1'b0, B};
    {sub_borrow, sub_res} = {1'b0, A} - {1'b0, B};
  end
`else
  // Plain modulo-2^WIDTH add/sub; carries are not needed without flags
  always_comb begin
    add_res = A + B;
    sub_res = A - B;
  end
`endif

  // Next-result select; reserved opcodes and the MVHI low half keep the current value
  always_comb begin
    next_out = out;
    case (opsel)
      OP_ADD:  next_out = add_res;
      OP_SUB:  next_out = sub_res;
      OP_AND:  next_out = A & B;
      OP_OR:   next_out = A | B;
      OP_XOR:  next_out = A ^ B;
      OP_NAND: next_out = ~(A & B);
      OP_NOR:  next_out = ~(A | B);
      OP_XNOR: next_out = ~(A ^ B);
      OP_MVHI: next_out = {B[HALF-1:0], out[HALF-1:0]};
      default: next_out = out;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Carry/overflow only meaningful for ADD and SUB; cf on SUB is "no borrow"
  always_comb begin
    reserved = (opsel > OP_MVHI);
    next_cf  = 1'b0;
    next_vf  = 1'b0;
    if (opsel == OP_ADD) begin
      next_cf = add_carry;
      next_vf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
    end else if (opsel == OP_SUB) begin
      next_cf = ~sub_borrow;
      next_vf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
    end
  end

  // Flags follow out on the same edge and freeze on reserved opcodes
  always_ff @(posedge clk) begin
    if (reset) begin
      zf <= 1'b0;
      nf <= 1'b0;
      cf <= 1'b0;
      vf <= 1'b0;
    end else if (!reserved) begin
      zf <= (next_out == '0);
      nf <= next_out[WIDTH-1];
      cf <= next_cf;
      vf <= next_vf;
    end
  end
`endif

  // Result register; reset wins over any opcode
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= next_out;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - table-driven self-checking bench for alu
module tb_alu;

  logic        clk;
  logic        reset;
  logic [3:0]  opsel;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] out;
`ifdef ALU_FLAGS_EN
  logic        zf, nf, cf, vf;
`endif

  int checks;
  int passed;

  alu dut (
    .clk   (clk),
    .reset (reset),
    .opsel (opsel),
    .A     (A),
    .B     (B),
`ifdef ALU_FLAGS_EN
    .zf    (zf),
    .nf    (nf),
    .cf    (cf),
    .vf    (vf),
`endif
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [3:0]  fl;  // {zf, nf, cf, vf}
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_flags(input string name, input logic [3:0] exp);
`ifdef ALU_FLAGS_EN
    chk({name, "_flags"}, {28'd0, zf, nf, cf, vf}, {28'd0, exp});
`else
    if (name.len() < 0 || exp === 4'hx) $display("unreachable");
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    passed = 0;

    vecs[0]  = '{4'd0,  32'd20,         32'd17,         32'd37,         4'b0000};
    vecs[1]  = '{4'd1,  32'd20,         32'd17,         32'd3,          4'b0010};
    vecs[2]  = '{4'd2,  32'd20,         32'd17,         32'd16,         4'b0000};
    vecs[3]  = '{4'd3,  32'd20,         32'd17,         32'd21,         4'b0000};
    vecs[4]  = '{4'd4,  32'd20,         32'd17,         32'd5,          4'b0000};
    vecs[5]  = '{4'd5,  32'd20,         32'd17,         32'hFFFF_FFEF,  4'b0100};
    vecs[6]  = '{4'd6,  32'd20,         32'd17,         32'hFFFF_FFEA,  4'b0100};
    vecs[7]  = '{4'd7,  32'd20,         32'd17,         32'hFFFF_FFFA,  4'b0100};
    vecs[8]  = '{4'd8,  32'd20,         32'd17,         32'h0011_FFFA,  4'b0000};
    vecs[9]  = '{4'd8,  32'hDEAD_BEEF,  32'd17,         32'h0011_FFFA,  4'b0000};
    vecs[10] = '{4'd0,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000,  4'b1010};
    vecs[11] = '{4'd0,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b0101};
    vecs[12] = '{4'd1,  32'd0,          32'd1,          32'hFFFF_FFFF,  4'b0100};
    vecs[13] = '{4'd0,  32'd20,         32'd17,         32'd37,         4'b0000};
    vecs[14] = '{4'd9,  32'h1234_5678,  32'h0,          32'd37,         4'b0000};
    vecs[15] = '{4'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd37,         4'b0000};
    vecs[16] = '{4'd11, 32'h0,          32'h8000_0000,  32'd37,         4'b0000};
    vecs[17] = '{4'd12, 32'h7FFF_FFFF,  32'd1,          32'd37,         4'b0000};
    vecs[18] = '{4'd13, 32'hA5A5_A5A5,  32'h5A5A_5A5A,  32'd37,         4'b0000};
    vecs[19] = '{4'd14, 32'd1,          32'd1,          32'd37,         4'b0000};
    vecs[20] = '{4'd15, 32'd20,         32'd17,         32'd37,         4'b0000};

    // Reset held two cycles with live ADD operands
    reset = 1'b1;
    opsel = 4'd0;
    A     = 32'd20;
    B     = 32'd17;
    tick();
    chk("reset_c1", out, 32'd0);
    chk_flags("reset_c1", 4'b0000);
    tick();
    chk("reset_c2", out, 32'd0);
    reset = 1'b0;

    // Each vector is issued back-to-back, one per cycle
    foreach (vecs[i]) begin
      opsel = vecs[i].op;
      A     = vecs[i].a;
      B     = vecs[i].b;
      tick();
      chk($sformatf("vec%0d_op%0d", i, vecs[i].op), out, vecs[i].exp);
      chk_flags($sformatf("vec%0d", i), vecs[i].fl);
    end

    // Output must not follow inputs between edges
    opsel = 4'd1;
    A     = 32'd100;
    B     = 32'd1;
    #3;
    chk("hold_between_edges", out, 32'd37);
    tick();
    chk("sub_after_hold", out, 32'd99);

    // Reset mid-sequence clears out even with MVHI selected
    opsel = 4'd8;
    B     = 32'd17;
    reset = 1'b1;
    tick();
    chk("mid_reset", out, 32'd0);
    chk_flags("mid_reset", 4'b0000);
    reset = 1'b0;
    tick();
    chk("mvhi_after_reset", out, 32'h0011_0000);
    chk_flags("mvhi_after_reset", 4'b0000);
    B = 32'hFFFF_8001;
    tick();
    chk("mvhi_upper_only", out, 32'h8001_0000);
    chk_flags("mvhi_upper_only", 4'b0100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit registered arithmetic/logic unit for the processor datapath.
- Selects one of nine operations on operands A and B.
- Registers the result into out on each rising clock edge.
- The MVHI operation is a partial-register write: it replaces only the upper half of out and keeps the lower half from the previous cycle.

Parameters:
- WIDTH, 32, operand and result width; fixed at 32; MVHI semantics assume 32.
- OPW, 4, opsel width.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous reset, active-high
- opsel  input  4  operation select (encoding below)
- A  input  32  operand A
- B  input  32  operand B
- out  output  32  registered result; interpreted as two's-complement signed by consumers

Behaviour:
- One clock, clk; reset is synchronous and active-high, named reset.
- On a rising clk edge with reset=1: out <= 0. Reset has priority over opsel.
- On a rising clk edge with reset=0, out updates according to opsel.
- Latency: the result for inputs present before edge N is visible on out after edge N (1 cycle).
- There is no handshake; a new operation may be issued every cycle.
- Opcode encoding:
  - 0 ADD: out <= A + B, modulo 2^32; carry discarded.
  - 1 SUB: out <= A - B, modulo 2^32; borrow discarded.
  - 2 AND: out <= A & B.
  - 3 OR: out <= A | B.
  - 4 XOR: out <= A ^ B.
  - 5 NAND: out <= ~(A & B).
  - 6 NOR: out <= ~(A | B).
  - 7 XNOR: out <= ~(A ^ B).
  - 8 MVHI: out[31:16] <= B[15:0]; out[15:0] holds its current value. A is ignored.
  - 9-15: reserved; out holds its value (no change).
- Overflow: signed overflow wraps silently. No exceptions are raised.
- The output is held constant between edges, with no combinational path from inputs to out.
- Consecutive MVHI cycles with the same B leave out unchanged.
- Reset asserted mid-sequence clears out on that edge. The next non-reset MVHI therefore yields {B[15:0], 16'h0000}.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, the block adds four registered 1-bit outputs: zf, nf, cf, vf. They are updated on the same edge as out and cleared by reset.
  - zf = (new out == 0).
  - nf = new out[31].
  - cf = carry-out of ADD, or NOT borrow of SUB; 0 for all other opcodes.
  - vf = signed overflow of ADD/SUB; 0 for all other opcodes.
  - For reserved opcodes, all flags hold their values.
- When not defined, these ports do not exist and no flag logic is synthesized. Behaviour of out is identical in both builds.

Test Plan:
- Reset: reset=1 for 2 cycles with A=20, B=17, opsel=0 -> out=0; after reset deasserts, out=37 after the next edge.
- A=20, B=17: ADD -> 37; SUB -> 3; AND -> 16; OR -> 21; XOR -> 5; NAND -> -17; NOR -> -22; XNOR -> -6. Each value appears one cycle after opsel changes.
- MVHI partial write: after XNOR leaves out=0xFFFFFFFA, set opsel=8 with B=17 -> out=0x0011FFFA (1179642). After reset followed by MVHI with B=17 -> out=0x00110000.
- Wrap: A=0xFFFFFFFF, B=1, ADD -> 0 (zf=1, cf=1 if ALU_FLAGS_EN). A=0x7FFFFFFF, B=1, ADD -> 0x80000000 (vf=1, nf=1). A=0, B=1, SUB -> 0xFFFFFFFF.
- Reserved: with out=37, opsel=9..15 for several cycles with varying A/B -> out stays 37.
- Back-to-back: a different opcode every cycle -> out tracks each result with exactly 1-cycle latency and no skipped or duplicated results.
